id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset; sampled on rising clk edge only.
REQ-003 if_id_valid  input  1  instruction word from IF/ID latch is valid this cycle.
REQ-004 if_id_instr  input  16  instruction word: [15:11] opcode, [10] addressing_mode, [9:7] rd, [6:4] rs1, [3:1] rs2.
REQ-005 flush  input  1  branch/jump taken in EX; discard the instruction currently being decoded.
REQ-006 wb_en, wb_rd  input  1, 3  writeback of register wb_rd completes this cycle.
REQ-007 id_opcode  output  5  registered opcode to ID/EX latch; 5'h1F = NOP.
REQ-008 id_addressing_mode, id_rd, id_rs1, id_rs2  output  1, 3, 3, 3  registered decoded fields.
REQ-009 id_data_mem  output  4  registered instr[3:0], data-memory address.
REQ-010 id_instruction_mem  output  6  registered instr[5:0], jump/branch target.
REQ-011 id_s_r_amount  output  3  registered instr[3:1], shift/rotate amount.
REQ-012 id_valid  output  1  registered; outputs carry a real instruction.
REQ-013 id_stall  output  1  combinational; IF and IF/ID latch hold when high.
REQ-014 stall_count  output  8  saturating count of stall cycles (see Configuration).

Function
REQ-015 Writer class: opcode < 5'h18 writes rd; opcodes 5'h18-5'h1F write no register.
REQ-016 Source reads: rs1 read when opcode < 5'h1C; rs2 read additionally only when addressing_mode = 0.
REQ-017 Scoreboard: 8 busy bits, one per register; busy bit = pending write by an issued, not-yet-written-back instruction.
REQ-018 Effective busy(r) = busy[r] AND NOT (wb_en AND wb_rd == r); same-cycle writeback releases the hazard.
REQ-019 id_stall = if_id_valid AND NOT flush AND (any read source has effective busy set).
REQ-020 Issue: if_id_valid=1, flush=0, id_stall=0 -> next edge registers all decoded fields, id_valid=1; latency 1 cycle.
REQ-021 Bubble: if_id_valid=0, or flush=1, or id_stall=1 -> next edge id_valid=0, id_opcode=5'h1F, other fields 0.
REQ-022 Issue of a writer sets busy[rd]; wb_en clears busy[wb_rd]; same register set and cleared in one cycle -> set wins.
REQ-023 Flushed or stalled instructions never set busy bits.
REQ-024 Writeback to a register whose busy bit is clear is ignored (no error).
REQ-025 rd equal to its own source (e.g. rd=rs1) is not a hazard unless that source is already busy.
REQ-026 Register 0 has no special treatment.

Reset
REQ-027 rst=1 at an edge: id_valid=0, id_opcode=5'h1F, all other data outputs 0, all busy bits 0, stall_count=0.
REQ-028 rst overrides flush, issue and writeback in the same cycle; in-flight scoreboard state is discarded.
REQ-029 id_stall is 0 during the first cycle after reset, since all busy bits are clear.

Configuration
REQ-030 Macro ID_STALL_CNT_EN defined: stall_count increments by 1 on each edge where id_stall=1, saturating at 8'hFF; cleared only by rst.
REQ-031 Macro ID_STALL_CNT_EN undefined: stall_count constantly 8'h00, no counter register; all other behaviour identical.

Verification
REQ-032 Reset then instr 16'h0A52 (op 5'h01, mode 0, rd 4, rs1 5, rs2 1) valid -> next cycle id_valid=1, id_rd=4, id_rs1=5, id_rs2=1, busy[4]=1.
REQ-033 Writer to rd=3 issued, next instr reads rs1=3, no wb -> id_stall=1 and bubble (opcode 5'h1F) each cycle until wb_en=1, wb_rd=3; that cycle id_stall=0 and instr issues.
REQ-034 Hazard on rs2 with addressing_mode=1 -> no stall; same instr with addressing_mode=0 -> stall.
REQ-035 flush=1 with valid writer to rd=6 -> id_valid=0 next cycle, busy[6] remains 0.
REQ-036 Issue writer rd=2 while wb_en=1, wb_rd=2 -> busy[2]=1 afterwards.
REQ-037 With ID_STALL_CNT_EN defined, hold hazard 300 cycles -> stall_count=8'hFF; assert rst mid-stall -> stall_count=0, id_stall=0 next cycle.

Source files
------------

// File: rtl/id_stage.sv
// id_stage: decode stage with 8-entry register scoreboard for RAW hazards.
// Decodes the IF/ID word, stalls on busy sources, issues to the ID/EX latch.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   if_id_valid/instr   incoming instruction word and its valid flag
//   flush               discard the instruction being decoded
//   wb_en, wb_rd        writeback completing this cycle
//   id_*                registered decoded fields to ID/EX (NOP = 5'h1F)
//   id_stall            combinational hold request to IF and IF/ID
//   stall_count         saturating stall-cycle counter
// Optional feature macro: ID_STALL_CNT_EN enables the stall_count register;
// when undefined stall_count is tied to 8'h00.
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_id_valid,
  input  logic [15:0] if_id_instr,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [2:0]  wb_rd,
  output logic [4:0]  id_opcode,
  output logic        id_addressing_mode,
  output logic [2:0]  id_rd,
  output logic [2:0]  id_rs1,
  output logic [2:0]  id_rs2,
  output logic [3:0]  id_data_mem,
  output logic [5:0]  id_instruction_mem,
  output logic [2:0]  id_s_r_amount,
  output logic        id_valid,
  output logic        id_stall,
  output logic [7:0]  stall_count
);

  localparam logic [4:0] NOP = 5'h1F;

  logic [4:0] dec_op;
  logic       dec_mode;
  logic [2:0] dec_rd;
  logic [2:0] dec_rs1;
  logic [2:0] dec_rs2;

  assign dec_op   = if_id_instr[15:11];
  assign dec_mode = if_id_instr[10];
  assign dec_rd   = if_id_instr[9:7];
  assign dec_rs1  = if_id_instr[6:4];
  assign dec_rs2  = if_id_instr[3:1];

  logic is_writer;
  logic rd_rs1;
  logic rd_rs2;

  assign is_writer = dec_op < 5'h18;
  assign rd_rs1    = dec_op < 5'h1C;
  assign rd_rs2    = rd_rs1 && !dec_mode;

  logic [7:0] busy_q;
  logic [7:0] busy_d;
  logic [7:0] wb_mask;
  logic [7:0] set_mask;
  logic [7:0] eff_busy;

  // A writeback landing this cycle already releases its register.
  assign wb_mask  = wb_en ? (8'h01 << wb_rd) : 8'h00;
  assign eff_busy = busy_q & ~wb_mask;

  logic hazard;
  logic live;
  logic issue;

  assign hazard = (rd_rs1 && eff_busy[dec_rs1]) ||
                  (rd_rs2 && eff_busy[dec_rs2]);
  assign live   = if_id_valid && !flush;
  assign issue  = live && !hazard;

  assign id_stall = live && hazard;

  // OR-ing the set after the clear makes the new issue win on overlap.
  assign set_mask = (issue && is_writer) ? (8'h01 << dec_rd) : 8'h00;
  assign busy_d   = eff_busy | set_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q             <= '0;
      id_valid           <= 1'b0;
      id_opcode          <= NOP;
      id_addressing_mode <= 1'b0;
      id_rd              <= '0;
      id_rs1             <= '0;
      id_rs2             <= '0;
      id_data_mem        <= '0;
      id_instruction_mem <= '0;
      id_s_r_amount      <= '0;
    end else begin
      busy_q <= busy_d;
      if (issue) begin
        id_valid           <= 1'b1;
        id_opcode          <= dec_op;
        id_addressing_mode <= dec_mode;
        id_rd              <= dec_rd;
        id_rs1             <= dec_rs1;
        id_rs2             <= dec_rs2;
        id_data_mem        <= if_id_instr[3:0];
        id_instruction_mem <= if_id_instr[5:0];
        id_s_r_amount      <= if_id_instr[3:1];
      end else begin
        id_valid           <= 1'b0;
        id_opcode          <= NOP;
        id_addressing_mode <= 1'b0;
        id_rd              <= '0;
        id_rs1             <= '0;
        id_rs2             <= '0;
        id_data_mem        <= '0;
        id_instruction_mem <= '0;
        id_s_r_amount      <= '0;
      end
    end
  end

`ifdef ID_STALL_CNT_EN
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (id_stall && cnt_q != 8'hFF)
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign stall_count = cnt_q;
`else
  assign stall_count = 8'h00;
`endif

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed self-checking bench for id_stage.
// Each task drives one scenario and checks its own results inline.
module tb_id_stage;

  logic        clk;
  logic        rst;
  logic        if_id_valid;
  logic [15:0] if_id_instr;
  logic        flush;
  logic        wb_en;
  logic [2:0]  wb_rd;
  logic [4:0]  id_opcode;
  logic        id_addressing_mode;
  logic [2:0]  id_rd;
  logic [2:0]  id_rs1;
  logic [2:0]  id_rs2;
  logic [3:0]  id_data_mem;
  logic [5:0]  id_instruction_mem;
  logic [2:0]  id_s_r_amount;
  logic        id_valid;
  logic        id_stall;
  logic [7:0]  stall_count;

  int n_chk;
  int n_fail;

  id_stage dut (
    .clk                (clk),
    .rst                (rst),
    .if_id_valid        (if_id_valid),
    .if_id_instr        (if_id_instr),
    .flush              (flush),
    .wb_en              (wb_en),
    .wb_rd              (wb_rd),
    .id_opcode          (id_opcode),
    .id_addressing_mode (id_addressing_mode),
    .id_rd              (id_rd),
    .id_rs1             (id_rs1),
    .id_rs2             (id_rs2),
    .id_data_mem        (id_data_mem),
    .id_instruction_mem (id_instruction_mem),
    .id_s_r_amount      (id_s_r_amount),
    .id_valid           (id_valid),
    .id_stall           (id_stall),
    .stall_count        (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] enc(input logic [4:0] op,
                                      input logic m,
                                      input logic [2:0] rd,
                                      input logic [2:0] s1,
                                      input logic [2:0] s2);
    return {op, m, rd, s1, s2, 1'b0};
  endfunction

  // advance one edge; inputs are then changed 1 time unit after it
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_id_valid = 1'b0;
    if_id_instr = '0;
    flush       = 1'b0;
    wb_en       = 1'b0;
    wb_rd       = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    if_id_valid = 1'b1;
    if_id_instr = enc(5'h01, 1'b0, 3'd4, 3'd5, 3'd1);
    flush = 1'b1;
    wb_en = 1'b1;
    cyc();
    rst = 1'b0;
    idle();
    #1;
    n_chk++;
    if (id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid got %b exp 0", id_valid);
    end
    n_chk++;
    if (id_opcode !== 5'h1F) begin
      n_fail++;
      $display("FAIL reset_opcode got %h exp 1f", id_opcode);
    end
    n_chk++;
    if ({id_addressing_mode, id_rd, id_rs1, id_rs2, id_data_mem,
         id_instruction_mem, id_s_r_amount} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_fields got nonzero rd=%0d rs1=%0d", id_rd, id_rs1);
    end
    n_chk++;
    if (dut.busy_q !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_busy got %h exp 00", dut.busy_q);
    end
    n_chk++;
    if (stall_count !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_cnt got %h exp 00", stall_count);
    end
    if_id_valid = 1'b1;
    if_id_instr = enc(5'h01, 1'b0, 3'd1, 3'd2, 3'd3);
    #1;
    n_chk++;
    if (id_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall got %b exp 0", id_stall);
    end
    idle();
  endtask

  task automatic test_issue();
    do_reset();
    if_id_valid = 1'b1;
    if_id_instr = 16'h0A52;
    cyc();
    idle();
    n_chk++;
    if ({id_valid, id_opcode, id_addressing_mode} !== {1'b1, 5'h01, 1'b0}) begin
      n_fail++;
      $display("FAIL issue_op got v=%b op=%h m=%b exp v=1 op=01 m=0",
               id_valid, id_opcode, id_addressing_mode);
    end
    n_chk++;
    if ({id_rd, id_rs1, id_rs2} !== {3'd4, 3'd5, 3'd1}) begin
      n_fail++;
      $display("FAIL issue_regs got %0d %0d %0d exp 4 5 1",
               id_rd, id_rs1, id_rs2);
    end
    n_chk++;
    if ({id_data_mem, id_instruction_mem, id_s_r_amount} !==
        {4'h2, 6'h12, 3'd1}) begin
      n_fail++;
      $display("FAIL issue_imm got dm=%h im=%h sr=%0d exp 2 12 1",
               id_data_mem, id_instruction_mem, id_s_r_amount);
    end
    n_chk++;
    if (dut.busy_q !== 8'h10) begin
      n_fail++;
      $display("FAIL issue_busy got %h exp 10", dut.busy_q);
    end
    cyc();
    n_chk++;
    if ({id_valid, id_opcode, id_rd} !== {1'b0, 5'h1F, 3'd0}) begin
      n_fail++;
      $display("FAIL bubble got v=%b op=%h rd=%0d exp 0 1f 0",
               id_valid, id_opcode, id_rd);
    end
  endtask

  task automatic test_raw_stall();
    do_reset();
    if_id_valid = 1'b1;
    if_id_instr = enc(5'h02, 1'b1, 3'd3, 3'd0, 3'd0);
    cyc();
    if_id_instr = enc(5'h03, 1'b1, 3'd5, 3'd3, 3'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++;
      if (id_stall !== 1'b1) begin
        n_fail++;
        $display("FAIL raw_stall[%0d] got %b exp 1", i, id_stall);
      end
      cyc();
      n_chk++;
      if ({id_valid, id_opcode} !== {1'b0, 5'h1F}) begin
        n_fail++;
        $display("FAIL raw_bubble[%0d] got v=%b op=%h exp 0 1f",
                 i, id_valid, id_opcode);
      end
    end
    wb_en = 1'b1;
    wb_rd = 3'd3;
    #1;
    n_chk++;
    if (id_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL raw_release got %b exp 0", id_stall);
    end
    cyc();
    idle();
    n_chk++;
    if ({id_valid, id_opcode, id_rs1} !== {1'b1, 5'h03, 3'd3}) begin
      n_fail++;
      $display("FAIL raw_issue got v=%b op=%h rs1=%0d exp 1 03 3",
               id_valid, id_opcode, id_rs1);
    end
    n_chk++;
    if (dut.busy_q !== 8'h20) begin
      n_fail++;
      $display("FAIL raw_busy got %h exp 20", dut.busy_q);
    end
  endtask

  task automatic test_rs2_mode();
    do_reset();
    if_id_valid = 1'b1;
    if_id_instr = enc(5'h05, 1'b1, 3'd2, 3'd0, 3'd0);
    cyc();
    if_id_instr = enc(5'h04, 1'b1, 3'd6, 3'd0, 3'd2);
    #1;
    n_chk++;
    if (id_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL rs2_imm got %b exp 0", id_stall);
    end
    if_id_instr = enc(5'h04, 1'b0, 3'd6, 3'd0, 3'd2);
    #1;
    n_chk++;
    if (id_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL rs2_reg got %b exp 1", id_stall);
    end
    if_id_instr = enc(5'h1B, 1'b1, 3'd0, 3'd2, 3'd0);
    #1;
    n_chk++;
    if (id_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL rs1_1b got %b exp 1", id_stall);
    end
    if_id_instr = enc(5'h1C, 1'b0, 3'd0, 3'd2, 3'd2);
    #1;
    n_chk++;
    if (id_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL nosrc_1c got %b exp 0", id_stall);
    end
    if_id_valid = 1'b0;
    if_id_instr = enc(5'h04, 1'b0, 3'd6, 3'd2, 3'd2);
    #1;
    n_chk++;
    if (id_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_stall got %b exp 0", id_stall);
    end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    if_id_valid = 1'b1;
    flush = 1'b1;
    if_id_instr = enc(5'h06, 1'b0, 3'd6, 3'd1, 3'd1);
    cyc();
    idle();
    n_chk++;
    if ({id_valid, id_opcode} !== {1'b0, 5'h1F}) begin
      n_fail++;
      $display("FAIL flush_out got v=%b op=%h exp 0 1f", id_valid, id_opcode);
    end
    n_chk++;
    if (dut.busy_q !== 8'h00) begin
      n_fail++;
      $display("FAIL flush_busy got %h exp 00", dut.busy_q);
    end
    if_id_valid = 1'b1;
    if_id_instr = enc(5'h06, 1'b1, 3'd1, 3'd0, 3'd0);
    cyc();
    if_id_instr = enc(5'h07, 1'b1, 3'd2, 3'd1, 3'd0);
    flush = 1'b1;
    #1;
    n_chk++;
    if (id_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_hazard got %b exp 0", id_stall);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    if_id_valid = 1'b1;
    if_id_instr = enc(5'h08, 1'b1, 3'd2, 3'd0, 3'd0);
    cyc();
    if_id_instr = enc(5'h09, 1'b1, 3'd2, 3'd0, 3'd0);
    wb_en = 1'b1;
    wb_rd = 3'd2;
    cyc();
    idle();
    n_chk++;
    if ({id_valid, id_opcode} !== {1'b1, 5'h09}) begin
      n_fail++;
      $display("FAIL b2b_issue got v=%b op=%h exp 1 09", id_valid, id_opcode);
    end
    n_chk++;
    if (dut.busy_q !== 8'h04) begin
      n_fail++;
      $display("FAIL set_wins got %h exp 04", dut.busy_q);
    end
    if_id_valid = 1'b1;
    if_id_instr = enc(5'h0A, 1'b0, 3'd1, 3'd1, 3'd0);
    #1;
    n_chk++;
    if (id_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL self_src got %b exp 0", id_stall);
    end
    cyc();
    if_id_instr = enc(5'h18, 1'b1, 3'd7, 3'd0, 3'd0);
    wb_en = 1'b1;
    wb_rd = 3'd5;
    cyc();
    idle();
    n_chk++;
    if ({id_valid, id_opcode, id_rd} !== {1'b1, 5'h18, 3'd7}) begin
      n_fail++;
      $display("FAIL nonwriter_issue got v=%b op=%h rd=%0d exp 1 18 7",
               id_valid, id_opcode, id_rd);
    end
    n_chk++;
    if (dut.busy_q !== 8'h06) begin
      n_fail++;
      $display("FAIL nonwriter_busy got %h exp 06", dut.busy_q);
    end
  endtask

  task automatic test_stall_count();
    logic [7:0] exp5;
    logic [7:0] expf;
`ifdef ID_STALL_CNT_EN
    exp5 = 8'd5;
    expf = 8'hFF;
`else
    exp5 = 8'h00;
    expf = 8'h00;
`endif
    do_reset();
    if_id_valid = 1'b1;
    if_id_instr = enc(5'h0B, 1'b1, 3'd7, 3'd0, 3'd0);
    cyc();
    if_id_instr = enc(5'h0C, 1'b1, 3'd0, 3'd7, 3'd0);
    repeat (5) cyc();
    n_chk++;
    if (stall_count !== exp5) begin
      n_fail++;
      $display("FAIL cnt_5 got %h exp %h", stall_count, exp5);
    end
    repeat (295) cyc();
    n_chk++;
    if (id_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL cnt_hold got %b exp 1", id_stall);
    end
    n_chk++;
    if (stall_count !== expf) begin
      n_fail++;
      $display("FAIL cnt_sat got %h exp %h", stall_count, expf);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_chk++;
    if (stall_count !== 8'h00) begin
      n_fail++;
      $display("FAIL cnt_rst got %h exp 00", stall_count);
    end
    n_chk++;
    if (id_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL cnt_rst_stall got %b exp 0", id_stall);
    end
    idle();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    idle();
    #2;
    test_reset();
    test_issue();
    test_raw_stall();
    test_rs2_mode();
    test_flush();
    test_back_to_back();
    test_stall_count();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
